// File: rtl/or1200_keccak_rdbuf.sv
// Keccak digest read-out buffer: issues core starts, captures the digest, returns one word per read.
// Define OR1200_KECCAK_RDBUF_BSWAP_EN to byte-swap each returned word (little-endian lanes to big-endian).
module or1200_keccak_rdbuf #(
  parameter int WIDTH        = 32,
  parameter int DIGEST_WORDS = 8,
  parameter int PTR_W        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_freeze,
  input  logic                          kc_start,
  input  logic                          kc_rd,
  output logic                          core_start,
  input  logic                          core_done,
  input  logic [DIGEST_WORDS*WIDTH-1:0] core_digest,
  output logic                          keccak_stall,
  output logic                          keccak_busy,
  output logic [WIDTH-1:0]              keccak_dataout,
  output logic                          keccak_valid
);

  typedef enum logic [1:0] {IDLE, RUN, READY} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [WIDTH-1:0] buf_q [DIGEST_WORDS];
  logic             acc_start, acc_rd, last_word;
  logic             do_start, do_read, capture;
  logic [WIDTH-1:0] rd_word, out_word;

  // Stall depends only on registered state so it never forms a loop with core_done.
  assign keccak_stall = kc_rd & (state == RUN);
  assign keccak_busy  = (state == RUN);
  assign acc_start    = kc_start & ~ex_freeze & ~keccak_stall;
  assign acc_rd       = kc_rd & ~ex_freeze & ~keccak_stall;
  assign last_word    = (ptr == PTR_W'(DIGEST_WORDS - 1));

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    do_start  = 1'b0;
    do_read   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (acc_start) begin
          do_start  = 1'b1;
          ptr_nxt   = '0;
          state_nxt = RUN;
        end else if (acc_rd) begin
          do_read = 1'b1;
        end
      end
      RUN: begin
        if (core_done) begin
          capture   = 1'b1;
          ptr_nxt   = '0;
          state_nxt = READY;
        end
      end
      READY: begin
        if (acc_start) begin
          do_start  = 1'b1;
          ptr_nxt   = '0;
          state_nxt = RUN;
        end else if (acc_rd) begin
          do_read = 1'b1;
          if (last_word) begin
            ptr_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reads outside READY return zero rather than hanging the pipeline.
  assign rd_word = (state == READY) ? buf_q[ptr] : '0;

`ifdef OR1200_KECCAK_RDBUF_BSWAP_EN
  function automatic logic [WIDTH-1:0] bswap(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      r[8*i +: 8] = w[WIDTH-8-8*i +: 8];
    end
    return r;
  endfunction
  assign out_word = bswap(rd_word);
`else
  assign out_word = rd_word;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGEST_WORDS; i++) buf_q[i] <= '0;
      keccak_dataout <= '0;
      keccak_valid   <= 1'b0;
      core_start     <= 1'b0;
    end else begin
      core_start   <= do_start;
      keccak_valid <= do_read;
      if (capture) begin
        for (int i = 0; i < DIGEST_WORDS; i++) buf_q[i] <= core_digest[i*WIDTH +: WIDTH];
      end
      // Output holds between reads so it stays stable across a WB freeze.
      if (do_read) keccak_dataout <= out_word;
    end
  end

endmodule
